// File: rtl/chunk_fetch_sched.sv
// Fetch scheduler: shares a chunk streamer's wide-word fetch port among NSRC sources,
// with fixed or round-robin selection and a timeout that always completes the fetch.
module chunk_fetch_sched #(
    parameter int WIDTH   = 48,
    parameter int WSB     = WIDTH - 1,
    parameter int NSRC    = 4,
    parameter int SBITS   = 2,
    parameter int SSB     = SBITS - 1,
    parameter int TIMEOUT = 15,
    parameter int TBITS   = 8,
    parameter int DELAY   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_i,
    output logic                  ready_o,
    output logic [WSB:0]          value_o,
    input  logic                  mode_i,
    input  logic [SSB:0]          sel_i,
    input  logic [NSRC-1:0]       src_rdy_i,
    output logic [NSRC-1:0]       src_get_o,
    input  logic [NSRC-1:0]       src_ack_i,
    input  logic [NSRC*WIDTH-1:0] src_dat_i,
    output logic [SSB:0]          grant_o,
    output logic                  busy_o,
    output logic                  err_o,
    input  logic                  clr_i
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [TBITS-1:0]  cnt_q, cnt_d;
    logic [SSB:0]      ptr_q, ptr_d;
    logic [SSB:0]      grant_d;
    logic [NSRC-1:0]   get_d;
    logic [WSB:0]      value_d;
    logic              ready_d;
    logic              err_d;

    logic              cand_vld;
    logic [SSB:0]      cand_idx;
    logic              ack_hit;
    logic              tmo;
    logic [NSRC*WIDTH-1:0] dat_sh;
    int unsigned       idx;

    // DELAY only shaped the original's simulation timing; registers here update at the edge.
    if (DELAY < 0) begin : g_delay_unused
    end

    // Out-of-range sel_i shifts the mask to zero, so it never grants and times out.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        idx      = 0;
        if (!mode_i) begin
            if (|(src_rdy_i & (NSRC'(1) << sel_i))) begin
                cand_vld = 1'b1;
                cand_idx = sel_i;
            end
        end else begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                idx = (ptr_q + k) % NSRC;
                if (!cand_vld && |(src_rdy_i & (NSRC'(1) << idx))) begin
                    cand_vld = 1'b1;
                    cand_idx = SBITS'(idx);
                end
            end
        end
    end

    assign ack_hit = |(src_ack_i & (NSRC'(1) << grant_o));
    assign tmo     = (cnt_q == TBITS'(TIMEOUT - 1));
    assign dat_sh  = src_dat_i >> (grant_o * WIDTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_o;
        get_d   = '0;
        value_d = value_o;
        ready_d = 1'b0;
        err_d   = clr_i ? 1'b0 : err_o;
        case (state_q)
            S_IDLE: begin
                if (fetch_i) begin
                    state_d = S_ARB;
                    cnt_d   = '0;
                end
            end
            S_ARB: begin
                cnt_d = cnt_q + TBITS'(1);
                if (cand_vld) begin
                    grant_d = cand_idx;
                    get_d   = NSRC'(1) << cand_idx;
                    state_d = S_WAIT;
                    if (mode_i) ptr_d = SBITS'((cand_idx + 1) % NSRC);
                end else if (tmo) begin
                    value_d = '1;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + TBITS'(1);
                if (ack_hit) begin
                    value_d = dat_sh[WSB:0];
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else if (tmo) begin
                    value_d = '1;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_o   <= '0;
            src_get_o <= '0;
            value_o   <= '0;
            ready_o   <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_o   <= grant_d;
            src_get_o <= get_d;
            value_o   <= value_d;
            ready_o   <= ready_d;
            err_o     <= err_d;
            busy_o    <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_chunk_fetch_sched.sv
// Bench for chunk_fetch_sched: transaction-level timing model plus a per-cycle output compare,
// with directed cases pinned to literal values and a randomized phase.
module tb_chunk_fetch_sched;

    localparam int WIDTH   = 48;
    localparam int NSRC    = 4;
    localparam int SBITS   = 2;
    localparam int TIMEOUT = 15;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  fetch_i = 1'b0;
    logic                  ready_o;
    logic [WIDTH-1:0]      value_o;
    logic                  mode_i = 1'b0;
    logic [SBITS-1:0]      sel_i = '0;
    logic [NSRC-1:0]       src_rdy_i = '0;
    logic [NSRC-1:0]       src_get_o;
    logic [NSRC-1:0]       src_ack_i = '0;
    logic [NSRC*WIDTH-1:0] src_dat_i = '0;
    logic [SBITS-1:0]      grant_o;
    logic                  busy_o;
    logic                  err_o;
    logic                  clr_i = 1'b0;

    chunk_fetch_sched #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SBITS(SBITS), .TIMEOUT(TIMEOUT), .TBITS(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_i(fetch_i), .ready_o(ready_o),
        .value_o(value_o), .mode_i(mode_i), .sel_i(sel_i), .src_rdy_i(src_rdy_i),
        .src_get_o(src_get_o), .src_ack_i(src_ack_i), .src_dat_i(src_dat_i),
        .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o), .clr_i(clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Model state: one transaction described by its start edge and completion offset.
    int              cyc = 0;
    bit              active = 0;
    int              E0 = 0, D = 0;
    bit              tx_granted = 0, tx_success = 0;
    int              tx_g = 0;
    logic [WIDTH-1:0] tx_value = '0, prev_value = '0;
    int              prev_grant = 0;
    int              rr_ptr = 0;
    bit              exp_err = 0;
    int              lat = -1;
    int              txid = 0;
    bit              clr_force = 0, rand_clr = 0, noise_en = 0;
    int              n_cmp = 0, n_bad = 0;
    int              cd [NSRC] = '{default: -1};
    int              cdid [NSRC] = '{default: 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Edge counter and sticky-error rule: timeout beats clear, reset beats both.
    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) exp_err = 1'b0;
        else if (active && cyc == E0 + D && !tx_success) exp_err = 1'b1;
        else if (clr_i) exp_err = 1'b0;
    end

    always @(negedge clk_i) begin
        logic [NSRC-1:0]  e_get;
        logic [WIDTH-1:0] e_val;
        int               e_grant;
        bit               e_busy, e_rdy;
        if (cyc > 0) begin
            e_busy  = active && cyc >= E0 && cyc <= E0 + D;
            e_rdy   = active && cyc == E0 + D;
            e_get   = (active && tx_granted && cyc == E0 + 1) ? (NSRC'(1) << tx_g) : '0;
            e_grant = (active && tx_granted && cyc >= E0 + 1) ? tx_g : prev_grant;
            e_val   = (active && cyc >= E0 + D) ? tx_value : prev_value;
            chk("ready", 64'(ready_o), 64'(e_rdy));
            chk("busy", 64'(busy_o), 64'(e_busy));
            chk("src_get", 64'(src_get_o), 64'(e_get));
            chk("grant", 64'(grant_o), 64'(e_grant));
            chk("value", 64'(value_o), 64'(e_val));
            chk("err", 64'(err_o), 64'(exp_err));
        end
    end

    // Source model: acks lat cycles after its strobe; optional noise on non-granted acks.
    always @(posedge clk_i) begin
        #2;
        for (int n = 0; n < NSRC; n++) begin
            if (src_get_o[n] && lat >= 0) begin
                cd[n]   = lat;
                cdid[n] = txid;
            end
            src_ack_i[n] = (cd[n] == 0 && cdid[n] == txid) ||
                           (noise_en && !(tx_granted && n == tx_g) && $urandom_range(0, 3) == 0);
            if (cd[n] >= 0) cd[n]--;
        end
        clr_i = clr_force || (rand_clr && $urandom_range(0, 7) == 0);
    end

    task automatic tx_setup(input bit m, input int sel, input logic [NSRC-1:0] rdy, input int l);
        logic [63:0] r;
        txid++;
        mode_i    = m;
        sel_i     = SBITS'(sel);
        src_rdy_i = rdy;
        lat       = l;
        for (int n = 0; n < NSRC; n++) begin
            r = {$urandom, $urandom};
            src_dat_i[n*WIDTH +: WIDTH] = r[WIDTH-1:0];
        end
        tx_granted = 0;
        tx_g       = 0;
        if (!m) begin
            if (rdy[sel]) begin
                tx_granted = 1;
                tx_g       = sel;
            end
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                int i;
                i = (rr_ptr + k) % NSRC;
                if (!tx_granted && rdy[i]) begin
                    tx_granted = 1;
                    tx_g       = i;
                end
            end
            if (tx_granted) rr_ptr = (tx_g + 1) % NSRC;
        end
        tx_success = tx_granted && l >= 0 && l + 2 <= TIMEOUT;
        D          = tx_success ? l + 2 : TIMEOUT;
        tx_value   = tx_success ? src_dat_i[tx_g*WIDTH +: WIDTH] : '1;
        E0         = cyc + 1;
        active     = 1;
        fetch_i    = 1'b1;
    endtask

    task automatic tx_finish(input int gap, output int seen);
        seen = -1;
        for (int k = 0; k < TIMEOUT + 10; k++) begin
            @(negedge clk_i);
            if (ready_o) begin
                seen = cyc - E0;
                break;
            end
        end
        if (seen < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: got no ready_o within %0d cycles want ready", TIMEOUT + 10);
        end
        @(posedge clk_i);
        #1;
        prev_value = tx_value;
        if (tx_granted) prev_grant = tx_g;
        active  = 0;
        fetch_i = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clr_pulse();
        clr_force = 1;
        @(posedge clk_i);
        #1;
        clr_force = 0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int seen;
        int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
        int alt_exp [3] = '{3, 1, 3};
        logic [WIDTH-1:0] want;

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_value", 64'(value_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Fixed mode, same-cycle ack
        tx_setup(0, 2, 4'b1111, 0);
        src_dat_i[2*WIDTH +: WIDTH] = 48'h0123456789AB;
        tx_value = 48'h0123456789AB;
        tx_finish(1, seen);
        chk("basic_latency", 64'(seen), 64'd2);
        chk("basic_value", 64'(value_o), 64'h0123456789AB);
        chk("basic_grant", 64'(grant_o), 64'd2);
        chk("basic_err", 64'(err_o), 64'd0);

        // Round-robin fairness, back-to-back
        for (int t = 0; t < 6; t++) begin
            tx_setup(1, 0, 4'b1111, 0);
            tx_finish(0, seen);
            chk("rr_grant", 64'(grant_o), 64'(rr_exp[t]));
        end
        for (int t = 0; t < 3; t++) begin
            tx_setup(1, 0, 4'b1010, 0);
            tx_finish(0, seen);
            chk("rr_alt_grant", 64'(grant_o), 64'(alt_exp[t]));
        end
        fetch_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Late ack
        tx_setup(0, 0, 4'b1111, 5);
        want = tx_value;
        tx_finish(1, seen);
        chk("late_latency", 64'(seen), 64'd7);
        chk("late_value", 64'(value_o), 64'(want));
        chk("late_err", 64'(err_o), 64'd0);

        // Timeout: source never ready, then ready but silent
        tx_setup(0, 1, 4'b1101, 0);
        tx_finish(3, seen);
        chk("tmo_latency", 64'(seen), 64'd15);
        chk("tmo_value", 64'(value_o), 64'hFFFFFFFFFFFF);
        chk("tmo_err_sticky", 64'(err_o), 64'd1);
        tx_setup(0, 1, 4'b1111, -1);
        tx_finish(1, seen);
        chk("tmo2_latency", 64'(seen), 64'd15);
        chk("tmo2_value", 64'(value_o), 64'hFFFFFFFFFFFF);
        clr_pulse();
        chk("clr_err", 64'(err_o), 64'd0);

        // Boundary: ack on the last allowed edge, then one too late
        tx_setup(0, 3, 4'b1111, TIMEOUT - 2);
        want = tx_value;
        tx_finish(1, seen);
        chk("edge_ack_value", 64'(value_o), 64'(want));
        chk("edge_ack_err", 64'(err_o), 64'd0);
        tx_setup(0, 3, 4'b1111, TIMEOUT - 1);
        tx_finish(1, seen);
        chk("late_by_one_value", 64'(value_o), 64'hFFFFFFFFFFFF);
        chk("late_by_one_err", 64'(err_o), 64'd1);
        clr_pulse();

        // Clear coinciding with a timeout
        tx_setup(0, 1, 4'b0001, 0);
        wait_edge(E0 + D - 1);
        clr_force = 1;
        wait_edge(E0 + D);
        clr_force = 0;
        tx_finish(1, seen);
        chk("clr_vs_tmo_err", 64'(err_o), 64'd1);

        // Reset while waiting for an ack
        tx_setup(1, 0, 4'b1111, -1);
        wait_edge(E0 + 1);
        rst_i   = 1'b1;
        fetch_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        active     = 0;
        prev_value = '0;
        prev_grant = 0;
        rr_ptr     = 0;
        @(negedge clk_i);
        chk("rstw_busy", 64'(busy_o), 64'd0);
        chk("rstw_grant", 64'(grant_o), 64'd0);
        chk("rstw_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #1;
        tx_setup(1, 0, 4'b1111, 0);
        tx_finish(1, seen);
        chk("rstw_rr_grant", 64'(grant_o), 64'd0);

        // Randomized traffic
        noise_en = 1;
        rand_clr = 1;
        for (int t = 0; t < 200; t++) begin
            int l;
            l = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 16));
            tx_setup(bit'($urandom_range(0, 1)), int'($urandom_range(0, NSRC - 1)),
                     NSRC'($urandom), l);
            tx_finish(int'($urandom_range(0, 2)), seen);
        end
        noise_en = 0;
        rand_clr = 0;
        repeat (3) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chunk_fetch_sched.md
# chunk_fetch_sched

Fetch scheduler that shares the wide-word fetch port of a chunk streamer among `NSRC` word sources, such as correlator visibility banks or status registers. The streamer raises `fetch_i` when it needs a new `WIDTH`-bit word. The scheduler selects a source, either fixed by `sel_i` or round-robin over ready sources, strobes it, latches its word, and returns it with a one-cycle `ready_o`. A timeout counter guarantees the streamer never stalls: a dead source yields an all-ones word and sets a sticky error flag.

## Interface
- `WIDTH`, 48: word width, matching the streamer.
- `WSB`, WIDTH-1: word MSB.
- `NSRC`, 4: number of sources, 2..16.
- `SBITS`, 2: source index width, ceil(log2(NSRC)).
- `SSB`, SBITS-1: index MSB.
- `TIMEOUT`, 15: cycles allowed in ARB+WAIT before forced completion, 1..255.
- `TBITS`, 8: timeout counter width.
- `DELAY`, 3: simulation delay on registered assignments.

Ports (name, direction, width, meaning):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `fetch_i` in 1: streamer requests a word. Level signal, held until `ready_o` is sampled.
- `ready_o` out 1: one-cycle pulse; `value_o` is valid during it.
- `value_o` out WIDTH: fetched word, held until the next completion.
- `mode_i` in 1: 0 = fixed source `sel_i`, 1 = round-robin. Sampled in ARB.
- `sel_i` in SBITS: fixed-mode source index. Values ≥ NSRC never grant, so the fetch times out.
- `src_rdy_i` in NSRC: source *n* has a word available.
- `src_get_o` out NSRC: one-hot, one-cycle fetch strobe.
- `src_ack_i` in NSRC: source *n* presents its word this cycle.
- `src_dat_i` in NSRC*WIDTH: source *n* word at bits [n*WIDTH +: WIDTH].
- `grant_o` out SBITS: index of the last granted source.
- `busy_o` out 1: state ≠ IDLE.
- `err_o` out 1: sticky timeout flag.
- `clr_i` in 1: clears `err_o`.

## Operation
- There are four states: IDLE, ARB, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If `fetch_i` is high, go to ARB and clear the timeout counter.
- **ARB** (candidate selection)
  - Fixed mode: the candidate is `sel_i`, provided `src_rdy_i[sel_i]` is high.
  - Round-robin mode: the candidate is the first index *i* = ptr, ptr+1, … (mod NSRC) with `src_rdy_i[i]` high.
  - If a candidate exists: `grant_o` <= index, `src_get_o` <= one-hot(index), go to WAIT.
  - In round-robin mode, ptr <= (index+1) mod NSRC. ptr does not change in fixed mode.
  - If no candidate exists, stay in ARB.
- **WAIT**
  - If `src_ack_i[grant_o]` is high: `value_o` <= `src_dat_i` slice `grant_o`, go to DONE.
  - Ack bits of other sources are ignored.
  - An ack in the same cycle as `src_get_o` is legal.
- **DONE**
  - `ready_o` = 1 for exactly this cycle, then go to IDLE.
- **Timeout**
  - The counter increments on every edge in ARB or WAIT.
  - On an edge where the count equals TIMEOUT-1 and the success condition for that state is false: `value_o` <= all ones, `err_o` <= 1, go to DONE.
  - Success has priority over timeout in the same cycle.
- **Error flag**
  - `clr_i` clears `err_o`.
  - A timeout in the same cycle as `clr_i` wins: `err_o` stays 1.
- **Deasserted request**
  - `fetch_i` falling while busy does not abort. The sequence completes and the `ready_o` pulse is issued regardless.
- **Reset**
  - Priority over everything, including mid-operation.
  - Registers go to: state IDLE, `ready_o`=0, `src_get_o`=0, `value_o`=0, `grant_o`=0, ptr=0, counter=0, `err_o`=0, `busy_o`=0.

## Timing
- Best-case latency with the source ready and acking the same cycle:
  - `fetch_i` sampled at edge 0 → ARB.
  - Edge 1 → WAIT, `src_get_o` high.
  - Edge 2 → DONE, `ready_o` high.
  - Edge 3 → IDLE.
  - `ready_o` is therefore in the 3rd cycle after `fetch_i` is first seen high.
- The streamer drops `fetch_i` at the edge that samples `ready_o`. IDLE sees it low, so there is no double fetch.
- Back-to-back fetches: the next ARB is entered no earlier than 1 cycle after DONE, giving 4-cycle throughput.
- `src_get_o` is high for exactly one cycle per grant, and at most one bit is set.
- Worst case: `ready_o` is at most TIMEOUT+1 cycles after ARB entry.

## Test plan
- **Fixed mode basic:** `mode_i`=0, `sel_i`=2, src2 ready and acking the same cycle with 0x0123456789AB → `src_get_o`=0100 for 1 cycle; `ready_o` in the 3rd cycle after `fetch_i`; `value_o`=0x0123456789AB; `grant_o`=2; `err_o`=0.
- **Round-robin fairness:** `mode_i`=1, all ready, 6 consecutive fetches → grants 0,1,2,3,0,1. Then with only src1 and src3 ready → grants alternate 3,1,3.
- **Late ack:** source acks 5 cycles after `src_get_o` → `ready_o` 5 cycles later than best case; correct data; no error.
- **Timeout:** `sel_i`=1, src1 never ready, TIMEOUT=15 → `ready_o` after 15 cycles in ARB; `value_o`=0xFFFFFFFFFFFF; `err_o`=1 stays set until `clr_i`. Repeat with src1 ready but never acking → same result, with `src_get_o` pulsed once.
- **Boundary:** an ack on the same edge the counter reaches TIMEOUT-1 → real data, `err_o`=0. `clr_i` coinciding with a timeout → `err_o`=1.
- **Reset mid-WAIT:** assert `rst_i` while in WAIT → next cycle all outputs are at reset values, ptr=0; a following fetch in round-robin mode grants src0.
